// File: rtl/mem_line_reader_if.sv
// Bundle of the reader's control, memory-read and output-stream signals.
// master is the reader's view; slave is the surrounding system's view.
interface mem_line_reader_if #(
  parameter int unsigned ADR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 64
);
  localparam int unsigned LEN_WIDTH = $clog2(MAX_LEN + 1);

  logic                  start;
  logic [ADR_WIDTH-1:0]  base_adr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic [ADR_WIDTH-1:0]  rd_adr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  start, base_adr, length, rd_data, out_ready,
    output busy, done, rd_adr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_adr, length, rd_data, out_ready,
    input  busy, done, rd_adr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_line_reader.sv
// Streaming burst reader: walks consecutive words of a combinational-read memory
// and emits them through a 2-entry FIFO on a valid/ready stream.
module mem_line_reader #(
  parameter int unsigned ADR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_line_reader_if.master bus
);
  localparam int unsigned LEN_WIDTH = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;

  logic pop_c;
  logic push_c;
  logic push_last_c;

  // A push may land in a full FIFO only when the head leaves in the same cycle.
  assign pop_c       = bus.out_valid & bus.out_ready;
  assign push_c      = (state == READ) && (remaining != '0) && ((count != 2'd2) || pop_c);
  assign push_last_c = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      count         <= 2'd0;
      tail_data     <= '0;
      tail_last     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_adr    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              bus.rd_adr <= bus.base_adr;
              remaining  <= bus.length;
              bus.busy   <= 1'b1;
              state      <= READ;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end
        READ: begin
          if (push_c) begin
            bus.rd_adr <= bus.rd_adr + ADR_WIDTH'(1);
            remaining  <= remaining - LEN_WIDTH'(1);
            if (push_last_c) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_c && bus.out_last) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Head lives in out_data/out_last; tail holds the second entry.
      case ({push_c, pop_c})
        2'b10: begin
          if (count == 2'd0) begin
            bus.out_data <= bus.rd_data;
            bus.out_last <= push_last_c;
          end else begin
            tail_data <= bus.rd_data;
            tail_last <= push_last_c;
          end
          count         <= count + 2'd1;
          bus.out_valid <= 1'b1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            bus.out_data <= tail_data;
            bus.out_last <= tail_last;
          end
          count         <= count - 2'd1;
          bus.out_valid <= (count == 2'd2);
        end
        2'b11: begin
          if (count == 2'd1) begin
            bus.out_data <= bus.rd_data;
            bus.out_last <= push_last_c;
          end else begin
            bus.out_data <= tail_data;
            bus.out_last <= tail_last;
            tail_data    <= bus.rd_data;
            tail_last    <= push_last_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_reader.sv
// Scoreboard bench for mem_line_reader: expected words are queued when a burst
// is started and popped as the stream hands them over.
module tb_mem_line_reader;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] mem [0:255];
  exp_t sb[$];
  int n_checks;
  int n_fail;

  mem_line_reader_if bus ();

  mem_line_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.rd_data = mem[bus.rd_adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start_burst(input logic [7:0] base, input int len);
    bus.start    = 1'b1;
    bus.base_adr = base;
    bus.length   = 7'(len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.data = mem[8'(int'(base) + i)];
      e.last = (i == len - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_adr = 8'h00;
    bus.length = 7'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.out_valid, bus.out_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/valid/last=%b, required 0000",
               {bus.busy, bus.done, bus.out_valid, bus.out_last});
    end
    n_checks++;
    if (bus.rd_adr !== 8'h00 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got rd_adr=%h out_data=%h, required 00/00000000", bus.rd_adr, bus.out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int pops = 0, done_n = 0, done_k = -1;
    bus.out_ready = 1'b1;
    start_burst(8'h10, 4);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.rd_adr !== 8'h10 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_start: got busy=%b rd_adr=%h valid=%b, required 1/10/0", bus.busy, bus.rd_adr, bus.out_valid);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin done_n++; done_k = k; end
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL basic_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL basic_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        n_checks++;
        if (k != pops + 1) begin
          n_fail++;
          $display("FAIL basic_timing: word %0d got cycle %0d, required %0d", pops, k, pops + 1);
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 4 || done_n != 1 || done_k != 5 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got pops=%0d done_n=%0d done_k=%0d busy=%b, required 4/1/5/0",
               pops, done_n, done_k, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int pops = 0, done_n = 0;
    bus.out_ready = 1'b1;
    start_burst(8'hFE, 4);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) done_n++;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL wrap_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 4 || done_n != 1 || bus.rd_adr !== 8'h02) begin
      n_fail++;
      $display("FAIL wrap_end: got pops=%0d done_n=%0d rd_adr=%h, required 4/1/02", pops, done_n, bus.rd_adr);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    logic [7:0] base = 8'h50;
    logic [7:0] prev_adr = 8'h00;
    logic hold = 1'b0;
    int pops = 0, done_n = 0, occ;
    bus.out_ready = 1'b1;
    start_burst(base, 8);
    for (int k = 0; k < 300 && done_n == 0; k++) begin
      if (k > 0) @(negedge clk);
      bus.out_ready = (k < 4) ? pat[3 - k] : 1'($urandom_range(0, 1));
      if (bus.done) done_n++;
      if (hold) begin
        n_checks++;
        if (bus.rd_adr !== prev_adr) begin
          n_fail++;
          $display("FAIL bp_stall: got rd_adr=%h, required %h while full", bus.rd_adr, prev_adr);
        end
      end
      occ = int'(8'(bus.rd_adr - base)) - pops;
      n_checks++;
      if (occ < 0 || occ > 2) begin
        n_fail++;
        $display("FAIL bp_occupancy: got %0d words in flight, required 0..2", occ);
      end
      hold = (occ == 2) && !(bus.out_valid && bus.out_ready);
      prev_adr = bus.rd_adr;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL bp_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 8 || done_n != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_end: got pops=%0d done_n=%0d left=%0d, required 8/1/0", pops, done_n, sb.size());
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len0_ignore();
    int pops = 0, done_n = 0;
    bus.out_ready = 1'b1;
    start_burst(8'h99, 0);
    n_checks++;
    if ({bus.done, bus.busy, bus.out_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL len0_pulse: got done/busy/valid=%b, required 100", {bus.done, bus.busy, bus.out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy, bus.out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL len0_after: got done/busy/valid=%b, required 000", {bus.done, bus.busy, bus.out_valid});
    end
    start_burst(8'h30, 3);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      bus.start = (k == 1);
      bus.base_adr = 8'h80;
      bus.length = 7'd5;
      if (bus.done) done_n++;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ignore_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL ignore_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 3 || done_n != 1 || bus.rd_adr !== 8'h33 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_end: got pops=%0d done_n=%0d rd_adr=%h busy=%b, required 3/1/33/0",
               pops, done_n, bus.rd_adr, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0, done_n = 0;
    bus.out_ready = 1'b1;
    start_burst(8'h40, 8);
    for (int k = 0; k < 20 && pops < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rmid_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL rmid_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        pops++;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    n_checks++;
    if ({bus.busy, bus.done, bus.out_valid, bus.out_last} !== 4'b0000 ||
        bus.rd_adr !== 8'h00 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_reset: got busy/done/valid/last=%b rd_adr=%h data=%h, required 0000/00/00000000",
               {bus.busy, bus.done, bus.out_valid, bus.out_last}, bus.rd_adr, bus.out_data);
    end
    pops = 0;
    start_burst(8'h20, 2);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) done_n++;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rmid2_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL rmid2_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 2 || done_n != 1) begin
      n_fail++;
      $display("FAIL rmid2_end: got pops=%0d done_n=%0d, required 2/1", pops, done_n);
    end
  endtask

  task automatic test_max_len();
    int pops = 0, done_n = 0, done_k = -1, late = 0;
    bus.out_ready = 1'b1;
    start_burst(8'h00, 64);
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin done_n++; done_k = k; end
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL max_extra: got word %h, required none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last} !== e) begin
            n_fail++;
            $display("FAIL max_data: got %h/%b, required %h/%b", bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        if (k != pops + 1) late++;
        pops++;
      end
    end
    n_checks++;
    if (pops != 64 || late != 0 || done_n != 1 || done_k != 65) begin
      n_fail++;
      $display("FAIL max_end: got pops=%0d late=%0d done_n=%0d done_k=%0d, required 64/0/1/65",
               pops, late, done_n, done_k);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_ignore();
    test_reset_mid();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
